// File: rtl/bank_mem_arbiter.sv
// Round-robin arbiter that shares one single-port banked byte memory among NREQ
// requesters. After reset it can optionally zero-fill the whole memory first.
module bank_mem_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 10,
  parameter int DW      = 8,
  parameter bit INIT_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_wen,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               mem_wen,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  output logic               init_done
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {S_RST, S_INIT, S_RUN} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_cnt;
  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_rsp_vld;
  logic [DW-1:0]   r_rdata;
  logic            r_init_done;

  logic            w_found;
  logic [PW-1:0]   w_cand;
  logic [PW-1:0]   w_gidx;
  logic [NREQ-1:0] w_gnt;
  logic            w_hs;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = w_cand;
      end
    end
  end

  assign w_hs = (r_state == S_RUN) && w_found;

  always_comb begin
    w_gnt = '0;
    if (w_hs) w_gnt[w_gidx] = 1'b1;
  end

  always_comb begin
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_INIT: begin
        mem_wen  = 1'b1;
        mem_addr = r_cnt;
      end
      S_RUN: begin
        if (w_found) begin
          mem_wen   = req_wen[w_gidx];
          mem_addr  = req_addr[int'(w_gidx)*AW +: AW];
          mem_wdata = req_wdata[int'(w_gidx)*DW +: DW];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_RST;
      r_cnt       <= '0;
      r_ptr       <= PW'(NREQ-1);
      r_rsp_vld   <= '0;
      r_rdata     <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_rsp_vld <= '0;
      // Keep the last returned byte so rsp_rdata holds between responses.
      if (|r_rsp_vld) r_rdata <= mem_rdata;
      case (r_state)
        S_RST: begin
          if (INIT_EN) begin
            r_state <= S_INIT;
          end else begin
            r_state     <= S_RUN;
            r_init_done <= 1'b1;
          end
        end
        S_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt) begin
            r_state     <= S_RUN;
            r_init_done <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_hs) begin
            r_ptr <= w_gidx;
            if (!req_wen[w_gidx]) r_rsp_vld <= w_gnt;
          end
        end
        default: r_state <= S_RST;
      endcase
    end
  end

  assign req_ready = w_gnt;
  assign rsp_valid = r_rsp_vld;
  // Memory data arrives in the response cycle itself, so pass it straight through.
  assign rsp_rdata = (|r_rsp_vld) ? mem_rdata : r_rdata;
  assign init_done = r_init_done;

endmodule
